touch_slider_ctrl: RTL and testbench
====================================

Name: touch_slider_ctrl

Overview:
- Generalised touch-panel UI decoder for the LCD overlay.
- Maps each qualified touch sample (x,y) onto one of N vertical sliders (VAL_W-bit value each) or one of M buttons (single-cycle pulse).
- Adds sample debouncing, a shared multi-cycle restoring divider instead of a combinational divide, and update strobes.
- Sits between the touch-controller sample interface and the threshold/motor-control consumers.

Parameters:
- N_SLD, 6, number of sliders.
- N_BTN, 1, number of buttons.
- COORD_W, 16, coordinate width.
- VAL_W, 8, slider value width; full scale FS = 2^VAL_W-1.
- SLD_X, {16'h311,16'h311,16'h2C7,16'h2C7,16'h293,16'h293}, packed slider column centres, index 0 in the LSBs.
- SLD_TOP, {16'h109,16'h27,16'h109,16'h27,16'h109,16'h27}, packed slider top edges (value FS end).
- SLD_BOT, {16'h1C8,16'hD8,16'h1C8,16'hD8,16'h1C8,16'hD8}, packed slider bottom edges (value 0 end); each must exceed its SLD_TOP.
- SLD_RST, {8'h80,8'hFF,8'h80,8'hFF,8'h00,8'hFF}, packed slider reset values.
- SLD_TOL, 10, slider half-width in x.
- BTN_X, 16'h53, packed button centres, x.
- BTN_Y, 16'h1C3, packed button centres, y.
- BTN_TOL, 30, button half-size in x and y.
- DEB_N, 3, consecutive same-target samples required to qualify; must be ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- touch_valid  in  1  one-cycle strobe: touch_x/touch_y hold a new sample of a pressed panel
- touch_release  in  1  one-cycle strobe: panel released
- touch_x  in  COORD_W  sample x
- touch_y  in  COORD_W  sample y
- sld_val  out  N_SLD*VAL_W  packed registered slider values
- sld_upd  out  N_SLD  one-cycle pulse on the bit of the slider just written
- btn_pulse  out  N_BTN  one-cycle pulse per qualified press
- busy  out  1  high while the divider is running

Behaviour:
- Async reset: sld_val=SLD_RST, sld_upd=0, btn_pulse=0, busy=0, FSM=IDLE, debounce count=0, target=NONE. Reset mid-divide aborts the operation with no write.
- Hit test (registered target decode, 1 cycle):
  - Slider i is hit if |x-SLD_X[i]| < SLD_TOL and SLD_TOP[i] < y < SLD_BOT[i] (strict inequalities).
  - Button j is hit if |x-BTN_X[j]| < BTN_TOL and |y-BTN_Y[j]| < BTN_TOL.
  - Absolute differences are computed unsigned and underflow-safe.
  - Sliders take priority over buttons; the lowest index wins; no hit gives NONE.
- Debounce:
  - The counter increments on each touch_valid whose target equals the previous target.
  - It reloads to 1 on a target change, and clears on touch_release or a NONE target.
  - A target is qualified when count reaches DEB_N; the count saturates at DEB_N.
- Buttons: btn_pulse[j] asserts for exactly one cycle when button j first qualifies. Re-arm requires release or a target change, so holding a button does not repeat.
- Sliders: every touch_valid with a qualified slider target, arriving while FSM=IDLE, launches a conversion (drag tracking). Samples arriving while busy are dropped with no queue.
- FSM states:
  - IDLE→LOAD on launch. LOAD latches num=(SLD_BOT-y)*FS (COORD_W+VAL_W bits, no overflow) and den=SLD_BOT-SLD_TOP.
  - LOAD→DIV: restoring division, one quotient bit per cycle for exactly COORD_W+VAL_W cycles; busy=1 from LOAD through WR.
  - DIV→WR: sld_val[target] is written with the truncated quotient, and sld_upd[target] pulses in the same cycle the value becomes visible.
  - WR→IDLE.
  - Latency from launch sample edge to visible value: COORD_W+VAL_W+3 cycles (27 at defaults).
- Arithmetic: the quotient is ≤ FS by construction; the written value takes the low VAL_W bits. Input changes during DIV have no effect.
- Simultaneous touch_valid and touch_release: release wins, and the sample is discarded.

Optional Feature:
- Macro TOUCH_SLIDER_FILT_EN.
  - When defined, WR writes (old+quot+1)>>1 (VAL_W+1-bit intermediate), a first-order smoothing, and the FSM adds one cycle, giving a latency of +1.
  - When undefined, WR writes the raw quotient.

Decomposition:
- Package touch_ui_pkg holds:
  - the FSM state enum (IDLE, LOAD, DIV, WR);
  - target encoding constants (NONE, slider/button index split);
  - the default geometry constants above.
- One sub-module, touch_div_seq: a restoring divider with start/done handshake, parameterised by numerator width and denominator width.

Test Plan:
- Reset with nothing applied: sld_val matches SLD_RST, i.e. FF,00,FF,80,FF,80 for sliders 0..5; all pulses 0.
- 3 samples at (0x293,0x80): slider0 conversion after the 3rd sample, producing sld_val[0]=0x7E (88*255/177) and a one-cycle sld_upd[0] 27 cycles later.
- 3 samples at (0x293,0x10A): sld_val[1]=0xFD (190*255/191). A sample at y=0x109 (edge) gives no hit and no update.
- Samples at (0x53,0x1C3) held for 10 samples: exactly one btn_pulse[0]. After touch_release and 3 more samples: a second pulse.
- Target alternates slider0/slider2 every sample: never qualifies, no writes. A sample sent while busy=1 is dropped: exactly one sld_upd.
- rst asserted mid-DIV: sld_val returns to SLD_RST and busy drops immediately; no sld_upd after reset.

Source files
------------

// File: rtl/touch_ui_pkg.sv
// Shared types and default geometry for the touch-panel UI decoder.
// Holds the FSM state enum, the slider/button target encoding and the LCD overlay layout.
package touch_ui_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DIV  = 2'd2,
        WR   = 2'd3
    } state_t;

    // A target is either a slider or a button plus its index; both flags clear means NONE.
    localparam int IDX_W = 7;
    typedef struct packed {
        logic             is_sld;
        logic             is_btn;
        logic [IDX_W-1:0] idx;
    } tgt_t;

    localparam tgt_t TGT_NONE = '0;

    localparam int DEF_N_SLD   = 6;
    localparam int DEF_N_BTN   = 1;
    localparam int DEF_COORD_W = 16;
    localparam int DEF_VAL_W   = 8;

    localparam logic [DEF_N_SLD*DEF_COORD_W-1:0] DEF_SLD_X =
        {16'h311, 16'h311, 16'h2C7, 16'h2C7, 16'h293, 16'h293};
    localparam logic [DEF_N_SLD*DEF_COORD_W-1:0] DEF_SLD_TOP =
        {16'h109, 16'h027, 16'h109, 16'h027, 16'h109, 16'h027};
    localparam logic [DEF_N_SLD*DEF_COORD_W-1:0] DEF_SLD_BOT =
        {16'h1C8, 16'h0D8, 16'h1C8, 16'h0D8, 16'h1C8, 16'h0D8};
    localparam logic [DEF_N_SLD*DEF_VAL_W-1:0] DEF_SLD_RST =
        {8'h80, 8'hFF, 8'h80, 8'hFF, 8'h00, 8'hFF};
    localparam logic [DEF_N_BTN*DEF_COORD_W-1:0] DEF_BTN_X = 16'h053;
    localparam logic [DEF_N_BTN*DEF_COORD_W-1:0] DEF_BTN_Y = 16'h1C3;

    localparam int DEF_SLD_TOL = 10;
    localparam int DEF_BTN_TOL = 30;
    localparam int DEF_DEB_N   = 3;

endpackage

// File: rtl/touch_div_seq.sv
// Sequential restoring divider: one quotient bit per cycle, NUM_W cycles after start.
// done pulses for one cycle when quot holds the final result.
module touch_div_seq #(
    parameter int NUM_W = 24,
    parameter int DEN_W = 16,
    parameter int Q_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             done,
    output logic [Q_W-1:0]   quot
);
    localparam int CNT_W = $clog2(NUM_W + 1);

    logic [DEN_W-1:0] rem_q, rem_d;
    logic [NUM_W-1:0] quo_q, quo_d;
    logic [DEN_W-1:0] den_q, den_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             done_q, done_d;
    logic [DEN_W:0]   trial;

    // quo_q shifts numerator bits out of the top while quotient bits enter at the bottom.
    assign trial = {rem_q, quo_q[NUM_W-1]};

    always_comb begin
        // NOTE: every comb output gets a default first so no latch can be inferred.
        rem_d  = rem_q;
        quo_d  = quo_q;
        den_d  = den_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (start) begin
            rem_d = '0;
            quo_d = num;
            den_d = den;
            cnt_d = CNT_W'(NUM_W);
            run_d = 1'b1;
        end else if (run_q) begin
            if (trial >= {1'b0, den_q}) begin
                rem_d = DEN_W'(trial - {1'b0, den_q});
                quo_d = {quo_q[NUM_W-2:0], 1'b1};
            end else begin
                rem_d = trial[DEN_W-1:0];
                quo_d = {quo_q[NUM_W-2:0], 1'b0};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            den_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            den_q  <= den_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign quot = quo_q[Q_W-1:0];

endmodule

// File: rtl/touch_slider_ctrl.sv
// Touch-panel UI decoder: hit test, debounce, button pulses and slider value conversion.
// Define TOUCH_SLIDER_FILT_EN to average each new slider value with the old one.
module touch_slider_ctrl
    import touch_ui_pkg::*;
#(
    parameter int N_SLD   = DEF_N_SLD,
    parameter int N_BTN   = DEF_N_BTN,
    parameter int COORD_W = DEF_COORD_W,
    parameter int VAL_W   = DEF_VAL_W,
    parameter logic [N_SLD*COORD_W-1:0] SLD_X   = DEF_SLD_X,
    parameter logic [N_SLD*COORD_W-1:0] SLD_TOP = DEF_SLD_TOP,
    parameter logic [N_SLD*COORD_W-1:0] SLD_BOT = DEF_SLD_BOT,
    parameter logic [N_SLD*VAL_W-1:0]   SLD_RST = DEF_SLD_RST,
    parameter int SLD_TOL = DEF_SLD_TOL,
    parameter logic [N_BTN*COORD_W-1:0] BTN_X   = DEF_BTN_X,
    parameter logic [N_BTN*COORD_W-1:0] BTN_Y   = DEF_BTN_Y,
    parameter int BTN_TOL = DEF_BTN_TOL,
    parameter int DEB_N   = DEF_DEB_N
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     touch_valid,
    input  logic                     touch_release,
    input  logic [COORD_W-1:0]       touch_x,
    input  logic [COORD_W-1:0]       touch_y,
    output logic [N_SLD*VAL_W-1:0]   sld_val,
    output logic [N_SLD-1:0]         sld_upd,
    output logic [N_BTN-1:0]         btn_pulse,
    output logic                     busy
);
    localparam int NUM_W = COORD_W + VAL_W;
    localparam int CNT_W = $clog2(DEB_N + 1);
    localparam logic [CNT_W-1:0]   DEB_MAX   = CNT_W'(DEB_N);
    localparam logic [NUM_W-1:0]   FS        = NUM_W'((1 << VAL_W) - 1);
    localparam logic [COORD_W-1:0] SLD_TOL_C = COORD_W'(SLD_TOL);
    localparam logic [COORD_W-1:0] BTN_TOL_C = COORD_W'(BTN_TOL);

    function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                     input logic [COORD_W-1:0] b);
        return (a >= b) ? a - b : b - a;
    endfunction

    logic                 hit_vld_q, hit_vld_d;
    tgt_t                 hit_tgt_q, hit_tgt_d;
    logic [COORD_W-1:0]   hit_y_q, hit_y_d;
    tgt_t                 prev_q, prev_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_BTN-1:0]     btn_q, btn_d;
    logic                 launch;
    state_t               state_q, state_d;
    logic [IDX_W-1:0]     sel_q, sel_d;
    logic [COORD_W-1:0]   y_q, y_d;
    logic [N_SLD*VAL_W-1:0] val_q, val_d;
    logic [N_SLD-1:0]     upd_q, upd_d;
    logic [COORD_W-1:0]   bot_sel, top_sel;
    logic [NUM_W-1:0]     div_num;
    logic [COORD_W-1:0]   div_den;
    logic                 div_start, div_done;
    logic [VAL_W-1:0]     div_quot;
    logic                 wr_en;
    logic [VAL_W-1:0]     wr_val;
`ifdef TOUCH_SLIDER_FILT_EN
    logic                 filt_pend_q, filt_pend_d;
    logic [VAL_W-1:0]     filt_val_q, filt_val_d;
    logic [VAL_W-1:0]     old_sel;
`endif

    // Hit test: sliders before buttons, lowest index first.
    always_comb begin
        hit_tgt_d = TGT_NONE;
        for (int j = N_BTN - 1; j >= 0; j--) begin
            if (abs_diff(touch_x, BTN_X[j*COORD_W +: COORD_W]) < BTN_TOL_C &&
                abs_diff(touch_y, BTN_Y[j*COORD_W +: COORD_W]) < BTN_TOL_C) begin
                hit_tgt_d = '{is_sld: 1'b0, is_btn: 1'b1, idx: IDX_W'(j)};
            end
        end
        for (int i = N_SLD - 1; i >= 0; i--) begin
            if (abs_diff(touch_x, SLD_X[i*COORD_W +: COORD_W]) < SLD_TOL_C &&
                touch_y > SLD_TOP[i*COORD_W +: COORD_W] &&
                touch_y < SLD_BOT[i*COORD_W +: COORD_W]) begin
                hit_tgt_d = '{is_sld: 1'b1, is_btn: 1'b0, idx: IDX_W'(i)};
            end
        end
        hit_vld_d = touch_valid & ~touch_release;
        if (!hit_vld_d) hit_tgt_d = hit_tgt_q;
        hit_y_d = hit_vld_d ? touch_y : hit_y_q;
    end

    // Debounce and qualification; a release also kills a sample still in the hit stage.
    always_comb begin
        cnt_d  = cnt_q;
        prev_d = prev_q;
        btn_d  = '0;
        launch = 1'b0;
        if (touch_release) begin
            cnt_d  = '0;
            prev_d = TGT_NONE;
        end else if (hit_vld_q) begin
            if (hit_tgt_q == TGT_NONE) begin
                cnt_d  = '0;
                prev_d = TGT_NONE;
            end else if (hit_tgt_q == prev_q) begin
                if (cnt_q < DEB_MAX) cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d  = CNT_W'(1);
                prev_d = hit_tgt_q;
            end
            if (cnt_d == DEB_MAX) begin
                if (hit_tgt_q.is_btn && !(hit_tgt_q == prev_q && cnt_q == DEB_MAX)) begin
                    for (int j = 0; j < N_BTN; j++)
                        if (hit_tgt_q.idx == IDX_W'(j)) btn_d[j] = 1'b1;
                end
                if (hit_tgt_q.is_sld && state_q == IDLE) launch = 1'b1;
            end
        end
    end

    always_comb begin
        bot_sel = '0;
        top_sel = '0;
        for (int i = 0; i < N_SLD; i++) begin
            if (sel_q == IDX_W'(i)) begin
                bot_sel = SLD_BOT[i*COORD_W +: COORD_W];
                top_sel = SLD_TOP[i*COORD_W +: COORD_W];
            end
        end
        div_num = NUM_W'(bot_sel - y_q) * FS;
        div_den = bot_sel - top_sel;
    end

`ifdef TOUCH_SLIDER_FILT_EN
    always_comb begin
        old_sel = '0;
        for (int i = 0; i < N_SLD; i++)
            if (sel_q == IDX_W'(i)) old_sel = val_q[i*VAL_W +: VAL_W];
    end
`endif

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        y_d       = y_q;
        div_start = 1'b0;
        wr_en     = 1'b0;
        wr_val    = div_quot;
`ifdef TOUCH_SLIDER_FILT_EN
        filt_pend_d = filt_pend_q;
        filt_val_d  = filt_val_q;
`endif
        case (state_q)
            IDLE: if (launch) begin
                state_d = LOAD;
                sel_d   = hit_tgt_q.idx;
                y_d     = hit_y_q;
            end
            LOAD: begin
                div_start = 1'b1;
                state_d   = DIV;
            end
            DIV: begin
`ifdef TOUCH_SLIDER_FILT_EN
                if (filt_pend_q) begin
                    wr_en       = 1'b1;
                    wr_val      = filt_val_q;
                    filt_pend_d = 1'b0;
                    state_d     = WR;
                end else if (div_done) begin
                    filt_pend_d = 1'b1;
                    filt_val_d  = VAL_W'(({1'b0, old_sel} + {1'b0, div_quot} + 1'b1) >> 1);
                end
`else
                if (div_done) begin
                    wr_en   = 1'b1;
                    state_d = WR;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        val_d = val_q;
        upd_d = '0;
        for (int i = 0; i < N_SLD; i++) begin
            if (wr_en && sel_q == IDX_W'(i)) begin
                val_d[i*VAL_W +: VAL_W] = wr_val;
                upd_d[i]                = 1'b1;
            end
        end
    end

    touch_div_seq #(
        .NUM_W (NUM_W),
        .DEN_W (COORD_W),
        .Q_W   (VAL_W)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start),
        .num   (div_num),
        .den   (div_den),
        .done  (div_done),
        .quot  (div_quot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_vld_q <= 1'b0;
            hit_tgt_q <= TGT_NONE;
            hit_y_q   <= '0;
            prev_q    <= TGT_NONE;
            cnt_q     <= '0;
            btn_q     <= '0;
            state_q   <= IDLE;
            sel_q     <= '0;
            y_q       <= '0;
            val_q     <= SLD_RST;
            upd_q     <= '0;
`ifdef TOUCH_SLIDER_FILT_EN
            filt_pend_q <= 1'b0;
            filt_val_q  <= '0;
`endif
        end else begin
            hit_vld_q <= hit_vld_d;
            hit_tgt_q <= hit_tgt_d;
            hit_y_q   <= hit_y_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            btn_q     <= btn_d;
            state_q   <= state_d;
            sel_q     <= sel_d;
            y_q       <= y_d;
            val_q     <= val_d;
            upd_q     <= upd_d;
`ifdef TOUCH_SLIDER_FILT_EN
            filt_pend_q <= filt_pend_d;
            filt_val_q  <= filt_val_d;
`endif
        end
    end

    assign sld_val   = val_q;
    assign sld_upd   = upd_q;
    assign btn_pulse = btn_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_touch_slider_ctrl.sv
// Scoreboard bench for touch_slider_ctrl: stimulus queues expected pulses, a monitor
// checks each sld_upd/btn_pulse against the queue head for index, value and cycle.
module tb_touch_slider_ctrl;

    localparam logic [47:0] RST_VAL = 48'h80FF_80FF_00FF;
`ifdef TOUCH_SLIDER_FILT_EN
    localparam int LAT = 28;
`else
    localparam int LAT = 27;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        touch_valid, touch_release;
    logic [15:0] touch_x, touch_y;
    logic [47:0] sld_val;
    logic [5:0]  sld_upd;
    logic [0:0]  btn_pulse;
    logic        busy;

    touch_slider_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .touch_valid   (touch_valid),
        .touch_release (touch_release),
        .touch_x       (touch_x),
        .touch_y       (touch_y),
        .sld_val       (sld_val),
        .sld_upd       (sld_upd),
        .btn_pulse     (btn_pulse),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bit         is_btn;
        int         idx;
        logic [7:0] val;
        int         due;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mdl[6];
    int         errors = 0;
    int         checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 6; i++) mdl[i] = RST_VAL[i*8 +: 8];
    endtask

    task automatic push_sld(input int idx, input logic [7:0] q, input int launch_edge);
        logic [7:0] v;
`ifdef TOUCH_SLIDER_FILT_EN
        v = 8'((9'(mdl[idx]) + 9'(q) + 9'd1) >> 1);
`else
        v = q;
`endif
        mdl[idx] = v;
        sb.push_back('{is_btn: 1'b0, idx: idx, val: v, due: launch_edge + LAT});
    endtask

    task automatic push_btn(input int idx, input int qual_edge);
        sb.push_back('{is_btn: 1'b1, idx: idx, val: 8'h00, due: qual_edge + 1});
    endtask

    // Monitor: every output pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (sld_upd != '0 || btn_pulse != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", 64'({sld_upd, btn_pulse}), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("pulse_cycle", 64'(cyc), 64'(e.due));
                    if (e.is_btn) begin
                        check("btn_pulse", 64'(btn_pulse), 64'd1 << e.idx);
                        check("sld_upd_quiet", 64'(sld_upd), 64'd0);
                    end else begin
                        check("sld_upd", 64'(sld_upd), 64'd1 << e.idx);
                        check("sld_val", 64'(sld_val[e.idx*8 +: 8]), 64'(e.val));
                        check("btn_quiet", 64'(btn_pulse), 64'd0);
                    end
                end
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                e = sb.pop_front();
                check("missing_pulse_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y, output int edge_no);
        @(negedge clk);
        touch_x     = x;
        touch_y     = y;
        touch_valid = 1'b1;
        edge_no     = cyc + 1;
        @(negedge clk);
        touch_valid = 1'b0;
    endtask

    task automatic release_touch();
        @(negedge clk);
        touch_release = 1'b1;
        @(negedge clk);
        touch_release = 1'b0;
    endtask

    function automatic logic [47:0] mdl_vec();
        logic [47:0] v;
        for (int i = 0; i < 6; i++) v[i*8 +: 8] = mdl[i];
        return v;
    endfunction

    initial begin
        int e;
        rst = 1'b1;
        touch_valid = 1'b0;
        touch_release = 1'b0;
        touch_x = '0;
        touch_y = '0;
        mdl_reset();
        idle(3);
        check("rst_sld_val", 64'(sld_val), 64'(RST_VAL));
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pulses", 64'({sld_upd, btn_pulse}), 64'd0);
        rst = 1'b0;
        idle(3);
        check("idle_sld_val", 64'(sld_val), 64'(RST_VAL));

        // Slider 0: 88*255/177 = 126.
        for (int k = 0; k < 3; k++) send(16'h293, 16'h080, e);
        push_sld(0, 8'h7E, e);
        idle(3);
        check("busy_in_div", 64'(busy), 64'd1);
        idle(30);
        check("busy_after_wr", 64'(busy), 64'd0);
        check("sld0_value", 64'(sld_val[7:0]), 64'h7E);
        release_touch();

        // Slider 1: 190*255/191 = 253; a fourth sample while busy is dropped.
        for (int k = 0; k < 3; k++) send(16'h293, 16'h10A, e);
        push_sld(1, 8'hFD, e);
        idle(4);
        check("busy_before_drop", 64'(busy), 64'd1);
        send(16'h293, 16'h10A, e);
        idle(35);
        release_touch();
        check("after_sld1", 64'(sld_val), 64'(mdl_vec()));

        // Top edge is exclusive: no hit, no update.
        for (int k = 0; k < 3; k++) send(16'h293, 16'h109, e);
        idle(35);
        release_touch();
        check("edge_no_write", 64'(sld_val), 64'(mdl_vec()));

        // Held button pulses once; release re-arms it.
        for (int k = 0; k < 10; k++) begin
            send(16'h053, 16'h1C3, e);
            if (k == 2) push_btn(0, e);
        end
        release_touch();
        for (int k = 0; k < 3; k++) send(16'h053, 16'h1C3, e);
        push_btn(0, e);
        release_touch();
        idle(5);

        // Alternating slider0/slider2 never qualifies.
        for (int k = 0; k < 8; k++) send((k % 2 == 0) ? 16'h293 : 16'h2C7, 16'h080, e);
        idle(35);
        release_touch();
        check("alt_no_write", 64'(sld_val), 64'(mdl_vec()));

        // Reset during DIV aborts the conversion.
        for (int k = 0; k < 3; k++) send(16'h293, 16'h10A, e);
        idle(12);
        check("busy_pre_abort", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_sld_val", 64'(sld_val), 64'(RST_VAL));
        mdl_reset();
        @(negedge clk);
        rst = 1'b0;
        idle(40);
        check("post_abort_val", 64'(sld_val), 64'(RST_VAL));
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
